// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings driven by the decoder on muldiv_if.op
//   - FSM state type used by muldiv_unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    SIGN_FIX = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage <-> multiply/divide unit connection.
//   master (pipeline side) drives: start, op, src_a, src_b, flush,
//                                  mthi_we, mtlo_we, wr_data
//   slave  (muldiv_unit)   drives: busy, done, hi, lo
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, mthi_we, mtlo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, mthi_we, mtlo_we, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: combinational datapath retiring UNROLL bits per call.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in  : {upper, lower} working register
//             multiply: {partial product, remaining multiplier bits}
//             divide  : {partial remainder, remaining dividend / quotient}
//   opnd    : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_out : working register after UNROLL steps
module muldiv_step #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     sum;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    acc    = acc_in;
    rem_sh = '0;
    diff   = '0;
    sum    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        // Shift the next dividend bit into the remainder, trial-subtract.
        // Remainder < divisor, so a borrow always shows up in bit WIDTH.
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        if (!diff[WIDTH]) begin
          acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
          acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Add multiplicand if the current multiplier LSB is set, then shift
        // the carry-extended sum down into the product.
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc = {sum, acc[WIDTH-1:1]};
      end
    end
    acc_out = acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
//   clk   : clock
//   reset : synchronous active-high reset (aborts op, clears HI/LO)
//   bus   : muldiv_if.slave -- start/op/src_a/src_b launch, flush abort,
//           mthi_we/mtlo_we/wr_data direct HI/LO writes, busy/done/hi/lo out
// Parameters: WIDTH (even, >= 4), UNROLL (1, 2 or 4, divides WIDTH).
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand multiplies and
// divide-by-zero skip CALC and go straight to SIGN_FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int N     = WIDTH / UNROLL;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e state, state_n;

  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, acc_init, step_out;
  logic [WIDTH-1:0]   opnd, opnd_init;
  logic               is_div, q_neg, r_neg, div0;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_n, lo_n;

  // Start-cycle decode of the incoming operation.
  logic             is_div_in, signed_in, sa, sb, zero_a, zero_b, div0_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             early, load, calc_en, fix_en, mt_go;

  assign is_div_in = bus.op[1];
  assign signed_in = !bus.op[0];
  assign sa        = signed_in && bus.src_a[WIDTH-1];
  assign sb        = signed_in && bus.src_b[WIDTH-1];
  assign mag_a     = sa ? -bus.src_a : bus.src_a;
  assign mag_b     = sb ? -bus.src_b : bus.src_b;
  assign zero_a    = (bus.src_a == '0);
  assign zero_b    = (bus.src_b == '0);
  assign div0_in   = is_div_in && zero_b;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = is_div_in ? zero_b : (zero_a || zero_b);
`else
  assign early = 1'b0;
`endif

  // Divide-by-zero preloads its final answer {src_a, all ones} and the
  // accumulator is frozen through CALC, so early and full-length paths
  // agree. A zero-operand multiply likewise preloads a zero product.
  always_comb begin
    acc_init  = '0;
    opnd_init = '0;
    if (is_div_in) begin
      opnd_init = mag_b;
      acc_init  = div0_in ? {bus.src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a};
    end else begin
      opnd_init = mag_a;
      acc_init  = (zero_a || zero_b) ? '0 : {{WIDTH{1'b0}}, mag_b};
    end
  end

  muldiv_step #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (step_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state and datapath registers use non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control strobes; flush overrides everything.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    calc_en = 1'b0;
    fix_en  = 1'b0;
    if (!bus.flush) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            load    = 1'b1;
            state_n = early ? SIGN_FIX : CALC;
          end
        end
        CALC: begin
          calc_en = 1'b1;
          if (count == LAST) state_n = SIGN_FIX;
        end
        SIGN_FIX: begin
          fix_en  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      state_n = IDLE;
    end
  end

  assign mt_go    = (state == IDLE) && !bus.start && !bus.flush;
  assign bus.busy = ((state == IDLE) && bus.start) || (state != IDLE);
  assign bus.done = fix_en;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Apply result signs. Signed overflow (most-negative / -1) needs no
  // special case: magnitude quotient is 2^(WIDTH-1) with positive sign.
  always_comb begin
    hi_n = '0;
    lo_n = '0;
    if (is_div) begin
      lo_n = q_neg ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
      hi_n = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      {hi_n, lo_n} = q_neg ? -acc : acc;
    end
  end

  // Datapath, counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      div0   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (load) begin
        count  <= '0;
        acc    <= acc_init;
        opnd   <= opnd_init;
        is_div <= is_div_in;
        div0   <= div0_in;
        q_neg  <= div0_in ? 1'b0 : (sa ^ sb);
        r_neg  <= (is_div_in && !div0_in) ? sa : 1'b0;
      end else if (calc_en) begin
        count <= count + CNT_W'(1);
        if (!div0) acc <= step_out;
      end

      if (fix_en) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end else if (mt_go) begin
        if (bus.mthi_we) hi_q <= bus.wr_data;
        if (bus.mtlo_we) lo_q <= bus.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
//   u_a : WIDTH=32, UNROLL=1 (main vectors, flush, mt*, reset abort)
//   u_b : WIDTH=32, UNROLL=4 (shortened CALC, start ignored while busy)
// Cycle 0 is the cycle in which start is sampled.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZERO_CYC = 1;
`else
  localparam int ZERO_CYC = 33;
`endif

  logic clk;
  logic reset;

  muldiv_if #(.WIDTH(32)) ma ();
  muldiv_if #(.WIDTH(32)) mb ();

  muldiv_unit #(.WIDTH(32), .UNROLL(1)) u_a (.clk(clk), .reset(reset), .bus(ma));
  muldiv_unit #(.WIDTH(32), .UNROLL(4)) u_b (.clk(clk), .reset(reset), .bus(mb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  always @(posedge clk) begin
    if (ma.done) done_cnt_a <= done_cnt_a + 1;
    if (mb.done) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op on u_a, wait (bounded) for done, then check HI/LO.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit with_mtlo, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    ma.start = 1'b1; ma.op = o; ma.src_a = a; ma.src_b = b;
    if (with_mtlo) begin
      ma.mtlo_we = 1'b1;
      ma.wr_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    check({tag, "_busy_c0"}, 64'(ma.busy), 64'(1));
    @(posedge clk); #1;
    ma.start = 1'b0; ma.mtlo_we = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if (ma.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
    @(posedge clk); #1;
    check({tag, "_hi"}, 64'(ma.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(ma.lo), 64'(exp_lo));
  endtask

  initial begin
    int d0;
    int cyc;
    bit seen;

    reset = 1'b1;
    {ma.start, ma.flush, ma.mthi_we, ma.mtlo_we} = '0;
    {mb.start, mb.flush, mb.mthi_we, mb.mtlo_we} = '0;
    ma.op = OP_MULT; ma.src_a = '0; ma.src_b = '0; ma.wr_data = '0;
    mb.op = OP_MULT; mb.src_a = '0; mb.src_b = '0; mb.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 64'(ma.busy), 64'(0));
    check("rst_done", 64'(ma.done), 64'(0));
    check("rst_hi",   64'(ma.hi),   64'(0));
    check("rst_lo",   64'(ma.lo),   64'(0));
    check("rst_b_hi", 64'(mb.hi),   64'(0));

    // Multiply / divide vectors
    do_op("mult_m1x2",  OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("multu_m1x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 33, 32'h0000_0001, 32'hFFFF_FFFE);
    do_op("div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 33, 32'h0000_0000, 32'h8000_0000);
    do_op("divu_7d3",   OP_DIVU,  32'h0000_0007, 32'h0000_0003, 0, 33, 32'h0000_0001, 32'h0000_0002);
    do_op("divu_dz",    OP_DIVU,  32'h0000_0064, 32'h0000_0000, 0, ZERO_CYC, 32'h0000_0064, 32'hFFFF_FFFF);
    do_op("div_dz",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 0, ZERO_CYC, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    do_op("mult_zero",  OP_MULT,  32'h0000_0000, 32'h0000_0005, 0, ZERO_CYC, 32'h0000_0000, 32'h0000_0000);

    // MTHI/MTLO then flushed MULTU
    @(posedge clk); #1;
    ma.mthi_we = 1'b1; ma.wr_data = 32'h11;
    @(posedge clk); #1;
    ma.mthi_we = 1'b0; ma.mtlo_we = 1'b1; ma.wr_data = 32'h22;
    @(posedge clk); #1;
    ma.mtlo_we = 1'b0;
    @(negedge clk);
    check("mthi", 64'(ma.hi), 64'(32'h11));
    check("mtlo", 64'(ma.lo), 64'(32'h22));
    d0 = done_cnt_a;
    @(posedge clk); #1;                       // cycle 0
    ma.start = 1'b1; ma.op = OP_MULTU; ma.src_a = 32'd3; ma.src_b = 32'd5;
    @(posedge clk); #1;                       // cycle 1
    ma.start = 1'b0;
    ma.mthi_we = 1'b1; ma.wr_data = 32'h99;   // must be ignored while busy
    repeat (9) @(posedge clk);
    #1;                                       // cycle 10
    ma.mthi_we = 1'b0;
    ma.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_c10", 64'(ma.busy), 64'(1));
    @(posedge clk); #1;                       // cycle 11
    ma.flush = 1'b0;
    @(negedge clk);
    check("flush_busy_c11", 64'(ma.busy), 64'(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush_no_done", 64'(done_cnt_a - d0), 64'(0));
    check("flush_hi", 64'(ma.hi), 64'(32'h11));
    check("flush_lo", 64'(ma.lo), 64'(32'h22));

    // start together with mtlo_we: op result wins
    do_op("start_mtlo", OP_MULTU, 32'd3, 32'd5, 1, 33, 32'h0, 32'd15);

    // Reset during DIV
    d0 = done_cnt_a;
    @(posedge clk); #1;                       // cycle 0
    ma.start = 1'b1; ma.op = OP_DIV; ma.src_a = 32'd100; ma.src_b = 32'd7;
    @(posedge clk); #1;                       // cycle 1
    ma.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;                                       // cycle 5
    reset = 1'b1;
    @(posedge clk); #1;                       // cycle 6
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(ma.busy), 64'(0));
    check("rstmid_hi",   64'(ma.hi),   64'(0));
    check("rstmid_lo",   64'(ma.lo),   64'(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rstmid_no_done", 64'(done_cnt_a - d0), 64'(0));

    // UNROLL=4 instance, start re-asserted while busy
    d0 = done_cnt_b;
    @(posedge clk); #1;                       // cycle 0
    mb.start = 1'b1; mb.op = OP_MULTU; mb.src_a = 32'h1234_5678; mb.src_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;                       // cycle 1
    mb.start = 1'b0;
    @(posedge clk); #1;                       // cycle 2
    mb.start = 1'b1; mb.op = OP_DIVU; mb.src_a = 32'h1; mb.src_b = 32'h1;
    @(negedge clk);
    check("u4_busy_c2", 64'(mb.busy), 64'(1));
    @(posedge clk); #1;                       // cycle 3
    mb.start = 1'b0;
    cyc  = 3;
    seen = 1'b0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if (mb.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("u4_done_cyc", 64'(cyc), 64'(9));
    @(posedge clk); #1;                       // cycle 10
    check("u4_hi", 64'(mb.hi), 64'(32'h0B00_EA4E));
    check("u4_lo", 64'(mb.lo), 64'(32'h242D_2080));
    @(negedge clk);
    check("u4_busy_c10", 64'(mb.busy), 64'(0));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("u4_one_done", 64'(done_cnt_b - d0), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
